// File: rtl/hex_display_driver_pkg.sv
// Shared types and seven-segment constants for the hex display driver.
// All segment patterns are active-low {g,f,e,d,c,b,a}.
package hex_display_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        HOLD,
        OPEN
    } state_t;

    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Index n holds the pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/hex_display_driver_if.sv
// Valid/ready word stream from the NoC into the display driver.
interface hex_display_driver_if;
    logic [31:0] DataIn;
    logic        DataValid;
    logic        DataReady;

    modport master (output DataIn, output DataValid, input DataReady);
    modport slave  (input DataIn, input DataValid, output DataReady);
endinterface

// File: rtl/hex_display_driver_seg.sv
// One seven-segment digit: nibble to active-low pattern, or dark when blanked.
module hex_to_seven_seg
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_OFF : SEG_TABLE[nibble];

endmodule

// File: rtl/hex_display_driver.sv
// Display end of the NoC result stream: accepts a word, shows it as 8 hex
// digits and refuses the next word until it has been visible HOLD_COUNT cycles.
// Optional macro HEX_DISPLAY_LZB_EN blanks digits above the top non-zero nibble.
module hex_display_driver
    import hex_display_pkg::*;
#(
    parameter int HOLD_COUNT  = 50000000,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   Clock,
    input  logic                   Reset,
    hex_display_driver_if.slave    bus,
    output logic [COUNT_WIDTH-1:0] WordCount,
    output logic [6:0]             HEX0,
    output logic [6:0]             HEX1,
    output logic [6:0]             HEX2,
    output logic [6:0]             HEX3,
    output logic [6:0]             HEX4,
    output logic [6:0]             HEX5,
    output logic [6:0]             HEX6,
    output logic [6:0]             HEX7
);

    // Counter only ever holds HOLD_COUNT-1 down to 0.
    localparam int CNT_W = (HOLD_COUNT > 1) ? $clog2(HOLD_COUNT) : 1;
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_COUNT - 1);

    state_t           state;
    logic [31:0]      word_q;
    logic [CNT_W-1:0] hold_cnt;
    logic             ready_q;
    logic             xfer;
    logic [7:0][6:0]  seg;
    logic [7:0][6:0]  disp;
    logic [7:0]       blank;

    assign bus.DataReady = ready_q;
    assign xfer          = bus.DataValid && ready_q;

    // Accept/hold/reopen sequencing; DataReady is registered alongside state.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= EMPTY;
            word_q    <= '0;
            hold_cnt  <= '0;
            WordCount <= '0;
            ready_q   <= 1'b1;
        end else begin
            case (state)
                EMPTY, OPEN: begin
                    if (xfer) begin
                        state     <= HOLD;
                        word_q    <= bus.DataIn;
                        hold_cnt  <= HOLD_INIT;
                        WordCount <= WordCount + COUNT_WIDTH'(1);
                        ready_q   <= 1'b0;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state   <= OPEN;
                        ready_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state   <= EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_dig
        if (i == 0) begin : g_lsd
            // The least significant digit is always lit so zero reads "0".
            assign blank[i] = 1'b0;
        end else begin : g_upper
`ifdef HEX_DISPLAY_LZB_EN
            assign blank[i] = (word_q[31:4*i] == '0);
`else
            assign blank[i] = 1'b0;
`endif
        end

        hex_to_seven_seg u_seg (
            .nibble (word_q[4*i +: 4]),
            .blank  (blank[i]),
            .seg    (seg[i])
        );
    end

    // Dashes until the first word arrives; the word register drives the rest.
    assign disp = (state == EMPTY) ? {8{SEG_DASH}} : seg;

    assign HEX0 = disp[0];
    assign HEX1 = disp[1];
    assign HEX2 = disp[2];
    assign HEX3 = disp[3];
    assign HEX4 = disp[4];
    assign HEX5 = disp[5];
    assign HEX6 = disp[6];
    assign HEX7 = disp[7];

endmodule

// File: tb/tb_hex_display_driver.sv
// Scoreboard bench: two drivers (HOLD_COUNT 4 and 1) share clock and reset.
// Stimulus pushes the expected display/count per word; monitors pop on transfer.
module tb_hex_display_driver;

    typedef struct packed {
        logic [55:0] hex;
        logic [7:0]  wc;
    } exp_t;

`ifdef HEX_DISPLAY_LZB_EN
    localparam logic [6:0] LZ = 7'h7F;
    localparam bit LZB = 1'b1;
`else
    localparam logic [6:0] LZ = 7'h40;
    localparam bit LZB = 1'b0;
`endif

    localparam logic [55:0] HEX_DASH = {8{7'h3F}};
    localparam logic [55:0] HEX_1234 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21};
    localparam logic [55:0] HEX_5    = {{7{LZ}}, 7'h12};
    localparam logic [55:0] HEX_A5   = {{6{LZ}}, 7'h08, 7'h12};
    localparam logic [55:0] HEX_0    = {{7{LZ}}, 7'h40};

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    hex_display_driver_if bus_a ();
    hex_display_driver_if bus_b ();
    wire [7:0]      wc_a, wc_b;
    wire [7:0][6:0] hex_a, hex_b;

    hex_display_driver #(.HOLD_COUNT(4), .COUNT_WIDTH(8)) dut_a (
        .Clock(Clock), .Reset(Reset), .bus(bus_a.slave), .WordCount(wc_a),
        .HEX0(hex_a[0]), .HEX1(hex_a[1]), .HEX2(hex_a[2]), .HEX3(hex_a[3]),
        .HEX4(hex_a[4]), .HEX5(hex_a[5]), .HEX6(hex_a[6]), .HEX7(hex_a[7])
    );

    hex_display_driver #(.HOLD_COUNT(1), .COUNT_WIDTH(8)) dut_b (
        .Clock(Clock), .Reset(Reset), .bus(bus_b.slave), .WordCount(wc_b),
        .HEX0(hex_b[0]), .HEX1(hex_b[1]), .HEX2(hex_b[2]), .HEX3(hex_b[3]),
        .HEX4(hex_b[4]), .HEX5(hex_b[5]), .HEX6(hex_b[6]), .HEX7(hex_b[7])
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    bit   pend_a = 1'b0;
    bit   pend_b = 1'b0;
    bit   have_last_b = 1'b0;
    int   last_b = 0;
    exp_t ea, eb;

    // Active-high segment codes for 0..F.
    logic [6:0] seg_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    function automatic logic [55:0] disp_of(input logic [31:0] w);
        logic [55:0] r;
        bit          lead;
        r    = '0;
        lead = 1'b1;
        for (int d = 7; d >= 0; d--) begin
            logic [3:0] n;
            n = w[4*d +: 4];
            if (n != 4'h0 || d == 0) lead = 1'b0;
            r[7*d +: 7] = (LZB && lead) ? 7'h7F : ~seg_hi[n];
        end
        return r;
    endfunction

    function automatic logic [31:0] word_b(input int i);
        return 32'(i) * 32'h00F1_0203;
    endfunction

    task automatic wait_ready(input bit sel_b, input string nm);
        @(negedge Clock);
        for (int k = 0; k < 20; k++) begin
            if ((sel_b ? bus_b.DataReady : bus_a.DataReady) === 1'b1) break;
            @(negedge Clock);
        end
        chk(nm, 64'(sel_b ? bus_b.DataReady : bus_a.DataReady), 64'd1);
    endtask

    // Monitor A: after each accepting edge, compare display and count.
    initial begin
        forever begin
            @(negedge Clock);
            if (pend_a) begin
                if (q_a.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL a unexpected transfer: got word, expected none");
                end else begin
                    ea = q_a.pop_front();
                    chk("a display", 64'(hex_a), 64'(ea.hex));
                    chk("a count", 64'(wc_a), 64'(ea.wc));
                end
            end
            pend_a = !Reset && bus_a.DataValid && bus_a.DataReady;
        end
    end

    // Monitor B: same, plus spacing between consecutive transfers.
    initial begin
        forever begin
            @(negedge Clock);
            if (pend_b) begin
                if (q_b.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL b unexpected transfer: got word, expected none");
                end else begin
                    eb = q_b.pop_front();
                    chk("b display", 64'(hex_b), 64'(eb.hex));
                    chk("b count", 64'(wc_b), 64'(eb.wc));
                end
                if (have_last_b) chk("b spacing", 64'(cyc - last_b), 64'd2);
                have_last_b = 1'b1;
                last_b = cyc;
            end
            pend_b = !Reset && bus_b.DataValid && bus_b.DataReady;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int lo;
        Reset = 1'b1;
        bus_a.DataValid = 1'b0; bus_a.DataIn = '0;
        bus_b.DataValid = 1'b0; bus_b.DataIn = '0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("reset ready", 64'(bus_a.DataReady), 64'd1);
        chk("reset count", 64'(wc_a), 64'd0);
        chk("reset dash", 64'(hex_a), 64'(HEX_DASH));
        @(posedge Clock); #1 Reset = 1'b0;
        @(negedge Clock);
        chk("idle ready", 64'(bus_a.DataReady), 64'd1);
        chk("idle dash", 64'(hex_a), 64'(HEX_DASH));

        // First word, then a second presented during the hold window.
        @(posedge Clock); #1;
        bus_a.DataIn = 32'h1234ABCD; bus_a.DataValid = 1'b1;
        q_a.push_back('{hex: HEX_1234, wc: 8'd1});
        @(posedge Clock); #1;
        bus_a.DataIn = 32'h0000_0005;
        q_a.push_back('{hex: HEX_5, wc: 8'd2});
        lo = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clock);
            if (bus_a.DataReady) break;
            lo++;
            chk("hold keeps word", 64'(hex_a), 64'(HEX_1234));
        end
        chk("ready low cycles", 64'(lo), 64'd4);

        // Reset two cycles into the next hold, with a word pending.
        @(posedge Clock); #1;
        bus_a.DataIn = 32'h0000_00A5;
        @(posedge Clock); #1 Reset = 1'b1;
        @(posedge Clock); #1 Reset = 1'b0;
        q_a.push_back('{hex: HEX_A5, wc: 8'd1});
        @(negedge Clock);
        chk("mid-hold reset ready", 64'(bus_a.DataReady), 64'd1);
        chk("mid-hold reset count", 64'(wc_a), 64'd0);
        chk("mid-hold reset dash", 64'(hex_a), 64'(HEX_DASH));

        @(posedge Clock); #1;
        bus_a.DataIn = 32'h0;
        q_a.push_back('{hex: HEX_0, wc: 8'd2});
        wait_ready(1'b0, "a reopen");
        @(posedge Clock); #1 bus_a.DataValid = 1'b0;
        @(negedge Clock);
        chk("zero word display", 64'(hex_a), 64'(HEX_0));
        chk("a final count", 64'(wc_a), 64'd2);

        // Back-to-back stream through the HOLD_COUNT=1 driver.
        @(posedge Clock); #1;
        bus_b.DataValid = 1'b1;
        for (int i = 1; i <= 257; i++) begin
            bus_b.DataIn = word_b(i);
            q_b.push_back('{hex: disp_of(word_b(i)), wc: 8'(i)});
            wait_ready(1'b1, "b ready");
            @(posedge Clock); #1;
        end
        bus_b.DataValid = 1'b0;
        @(negedge Clock);
        chk("b wrap count", 64'(wc_b), 64'd1);

        repeat (3) @(negedge Clock);
        chk("a queue drained", 64'(q_a.size()), 64'd0);
        chk("b queue drained", 64'(q_b.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
